// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional overrun flag is enabled by defining KEYPAD_OVERRUN_EN.
package keypad_pkg;

  localparam int unsigned N_ROWS = 4;
  localparam int unsigned N_COLS = 4;
  localparam int unsigned KEY_W  = 4;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } state_e;

  // Index of the lowest active-low row; returns 0 when no row is low.
  function automatic logic [1:0] lowest_low(input logic [N_ROWS-1:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
// Each bit is synchronized independently; reset value is configurable.
module sync2 #(
  parameter int unsigned       Width    = 4,
  parameter logic [Width-1:0] ResetVal = '1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with tick-gated debounce and one-key-per-press reporting.
// Define KEYPAD_OVERRUN_EN to add the overrun output for presses dropped while a key is pending.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  tick,
  input  logic [N_ROWS-1:0]     row_n,
  output logic [N_COLS-1:0]     col_n,
  output logic [KEY_W-1:0]      key_code,
  output logic                  key_valid,
`ifdef KEYPAD_OVERRUN_EN
  output logic                  overrun,
`endif
  input  logic                  key_ack
);

  localparam logic [3:0] DebMax = 4'(DEB_TICKS);

  logic [N_ROWS-1:0] row_s;

  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cnt_inc;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             accept;

  sync2 #(
    .Width   (N_ROWS),
    .ResetVal('1)
  ) u_sync2 (
    .clk(clk),
    .clr(clr),
    .d_i(row_n),
    .q_o(row_s)
  );

  assign cnt_inc = cnt_q + 4'd1;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StScan;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= 4'd0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
    accept  = 1'b0;

    if (key_ack && valid_q) valid_d = 1'b0;

    case (state_q)
      StScan: begin
        if (tick) begin
          if (row_s != '1) begin
            // Column freezes on the one that exposed the press.
            row_d   = lowest_low(row_s);
            cnt_d   = 4'd0;
            state_d = StDebounce;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      StDebounce: begin
        if (tick) begin
          if (!row_s[row_q] && (lowest_low(row_s) == row_q)) begin
            if (cnt_inc == DebMax) begin
              accept  = 1'b1;
              cnt_d   = 4'd0;
              state_d = StHeld;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = StScan;
          end
        end
      end
      StHeld: begin
        if (tick) begin
          if (row_s == '1) begin
            if (cnt_inc == DebMax) begin
              cnt_d   = 4'd0;
              state_d = StRelease;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
      end
      StRelease: begin
        col_d   = col_q + 2'd1;
        cnt_d   = 4'd0;
        state_d = StScan;
      end
      default: begin
        state_d = StScan;
      end
    endcase

    // A pending key wins over a new press unless it is acknowledged this very cycle.
    if (accept && !(valid_q && !key_ack)) begin
      code_d  = {row_q, col_q};
      valid_d = 1'b1;
    end
  end

`ifdef KEYPAD_OVERRUN_EN
  logic overrun_q, overrun_d;
  logic drop;

  assign drop = accept & valid_q & ~key_ack;

  always_comb begin
    overrun_d = overrun_q;
    if (key_ack) overrun_d = 1'b0;
    if (drop)    overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) overrun_q <= 1'b0;
    else      overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

  assign col_n     = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a combinational 4x4 switch matrix model driven
// by col_n, ticks every 4 clk, with hand-computed expectations.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       clr;
  logic       tick;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
`ifdef KEYPAD_OVERRUN_EN
  logic       overrun;
`endif

  logic [15:0] press;  // bit r*4+c = switch at row r, column c closed

  int vectors    = 0;
  int miscompares = 0;

  keypad_scan #(
    .DEB_TICKS(4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .tick     (tick),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
`ifdef KEYPAD_OVERRUN_EN
    .overrun  (overrun),
`endif
    .key_ack  (key_ack)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(press[r*4 +: 4] & ~col_n);
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Three idle clocks then one tick clock, so synchronized rows settle before each tick.
  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) step();
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic ack();
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; tick = 1'b0; key_ack = 1'b0; press = '0;
    #2 clr = 1'b0;
    #1;
    check("reset_col_n", col_n, 4'b1110);
    check("reset_valid", key_valid, 0);
    check("reset_code", key_code, 0);
`ifdef KEYPAD_OVERRUN_EN
    check("reset_overrun", overrun, 0);
`endif
    step(); step();
    clr = 1'b1;

    // Row 2 / col 1: tick1 rotates to col1, tick2 detects, ticks 3..6 debounce.
    press[2*4+1] = 1'b1;
    do_tick(5);
    check("press_not_yet", key_valid, 0);
    do_tick(1);
    check("press_valid", key_valid, 1);
    check("press_code", key_code, 4'h9);
    check("frozen_col", col_n, 4'b1101);
    do_tick(4);
    check("held_valid", key_valid, 1);
    check("held_code", key_code, 4'h9);
    ack();
    check("ack_clears", key_valid, 0);
    do_tick(3);
    check("no_repeat", key_valid, 0);
    press = '0;
    do_tick(4);
    check("release_col_frozen", col_n, 4'b1101);
    step();
    check("release_next_col", col_n, 4'b1011);

    // tick low: nothing moves.
    repeat (100) step();
    check("idle_col", col_n, 4'b1011);
    do_tick(1);
    check("rotate_col3", col_n, 4'b0111);
    do_tick(1);
    check("rotate_wrap", col_n, 4'b1110);

    // Rows 1 and 3 together on col 0: lowest row wins.
    press[1*4+0] = 1'b1;
    press[3*4+0] = 1'b1;
    do_tick(4);
    check("multi_not_yet", key_valid, 0);
    do_tick(1);
    check("multi_valid", key_valid, 1);
    check("multi_code", key_code, 4'h4);
    ack();
    press = '0;
    do_tick(4);
    step();
    check("multi_release_col", col_n, 4'b1101);

    // Bounce on row 2 / col 1.
    press[2*4+1] = 1'b1;
    do_tick(2);
    check("bounce_a", key_valid, 0);
    press = '0;
    do_tick(1);
    check("bounce_b", key_valid, 0);
    check("bounce_col", col_n, 4'b1101);
    press[2*4+1] = 1'b1;
    do_tick(4);
    check("bounce_short", key_valid, 0);
    do_tick(1);
    check("bounce_valid", key_valid, 1);
    check("bounce_code", key_code, 4'h9);
    ack();
    press = '0;
    do_tick(4);
    step();
    check("bounce_release_col", col_n, 4'b1011);

    // Two presses without ack: second is dropped.
    press[0*4+2] = 1'b1;
    do_tick(5);
    check("first_valid", key_valid, 1);
    check("first_code", key_code, 4'h2);
    press = '0;
    do_tick(4);
    step();
    check("first_release_col", col_n, 4'b0111);
    press[3*4+3] = 1'b1;
    do_tick(5);
    check("drop_code", key_code, 4'h2);
    check("drop_valid", key_valid, 1);
`ifdef KEYPAD_OVERRUN_EN
    check("drop_overrun", overrun, 1);
`endif
    press = '0;
    do_tick(4);
    step();
    check("drop_release_col", col_n, 4'b1110);

    // Acceptance coinciding with ack: new key loads, valid stays high.
    press[1*4+0] = 1'b1;
    do_tick(4);
    check("coinc_pending", key_code, 4'h2);
    repeat (3) step();
    tick = 1'b1;
    key_ack = 1'b1;
    step();
    tick = 1'b0;
    key_ack = 1'b0;
    check("coinc_valid", key_valid, 1);
    check("coinc_code", key_code, 4'h4);
`ifdef KEYPAD_OVERRUN_EN
    check("coinc_overrun", overrun, 0);
`endif
    press = '0;
    do_tick(4);
    step();
    check("coinc_release_col", col_n, 4'b1101);

    // Reset mid-debounce with a key still pending.
    press[2*4+1] = 1'b1;
    do_tick(3);
    #2 clr = 1'b0;
    #1;
    check("mid_reset_col", col_n, 4'b1110);
    check("mid_reset_valid", key_valid, 0);
    check("mid_reset_code", key_code, 0);
    step(); step();
    clr = 1'b1;
    do_tick(5);
    check("redebounce_short", key_valid, 0);
    do_tick(1);
    check("redebounce_valid", key_valid, 1);
    check("redebounce_code", key_code, 4'h9);
    ack();
    check("final_ack", key_valid, 0);
    ack();
    check("stray_ack", key_valid, 0);
    press = '0;
    do_tick(4);
    step();
    check("final_col", col_n, 4'b1011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter DEB_TICKS, default 4: consecutive stable tick samples required to accept a press or a release (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-003 SHALL have port clr, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port tick, input, 1: scan/debounce enable pulse, driven by the prescaler carry-out; only cycles with tick=1 advance scanning and debounce.
REQ-005 SHALL have port row_n, input, 4: keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col_n, output, 4: column drive, one-hot active-low.
REQ-007 SHALL have port key_code, output, 4: accepted key, {row[1:0], col[1:0]}.
REQ-008 SHALL have port key_valid, output, 1: key_code holds an unacknowledged key.
REQ-009 SHALL have port key_ack, input, 1: consumer acknowledge, sampled every clk.

Function
REQ-010 SHALL pass row_n through a 2-flop synchronizer; the FSM sees only synchronized rows (2-cycle latency).
REQ-011 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-012 In SCAN, each tick SHALL rotate the driven column 0->1->2->3->0; wrap from 3 to 0 is seamless.
REQ-013 In SCAN, on a tick with any synchronized row low, SHALL latch the lowest-index low row and the current column, freeze col_n, clear the debounce count, and enter DEBOUNCE.
REQ-014 In DEBOUNCE, each tick with the latched row still low and no lower-index row low SHALL increment the count; any other row pattern SHALL return to SCAN with the count cleared.
REQ-015 When the count reaches DEB_TICKS, SHALL load key_code, assert key_valid on the next clk, and enter HELD.
REQ-016 In HELD, each tick with all rows high SHALL increment the count; any low row SHALL clear it; reaching DEB_TICKS SHALL enter RELEASE.
REQ-017 RELEASE SHALL last one clk, resume column rotation from the next column, and enter SCAN.
REQ-018 key_valid SHALL clear on the clk following key_ack=1; key_ack while key_valid=0 SHALL be ignored.
REQ-019 SHALL report one key per press; holding a key SHALL NOT repeat.
REQ-020 A press accepted while key_valid=1 SHALL be dropped; key_code SHALL hold the unacknowledged key.
REQ-021 Acceptance and key_ack in the same clk SHALL load the new key_code and leave key_valid=1.
REQ-022 tick held constantly high SHALL be legal and SHALL advance every clk.

Reset
REQ-023 clr=0 SHALL asynchronously force state SCAN, col_n=4'b1110, key_code=0, key_valid=0, count=0, synchronizer flops=4'b1111.
REQ-024 Reset mid-press SHALL discard the press; after release of clr, a still-held key SHALL be debounced afresh.

Configuration
REQ-025 With KEYPAD_OVERRUN_EN defined, SHALL add output overrun, 1 bit: set by a press dropped per REQ-020, cleared by key_ack, reset value 0.
REQ-026 Without KEYPAD_OVERRUN_EN, the overrun port and its logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-027 Package keypad_pkg SHALL hold the FSM state typedef, N_ROWS=4, N_COLS=4, and KEY_W=4.
REQ-028 The synchronizer SHALL be sub-module sync2, 4 bits wide; all other logic SHALL be in keypad_scan.

Verification
REQ-029 Tick every 4 clk; press row 2 while col 1 is driven, held 10 ticks -> key_code=4'h9, key_valid=1 after exactly DEB_TICKS stable ticks; no repeat while held.
REQ-030 Bounce: row low for 2 ticks, high for 1, then low -> no key_valid until 4 consecutive stable ticks are seen.
REQ-031 Rows 1 and 3 low together on col 0 -> key_code=4'h4.
REQ-032 Two presses without key_ack -> first key_code kept; overrun=1 when KEYPAD_OVERRUN_EN is defined; key_ack -> key_valid=0, overrun=0.
REQ-033 clr pulsed low during DEBOUNCE -> col_n=4'b1110, key_valid=0 immediately; the held key is accepted again only after a full debounce.
REQ-034 tick=0 for 100 clk -> col_n and state unchanged.
